// File: rtl/ddr3_vid_pkg.sv
// Shared constants and types for the DDR3 video write-address path.
package ddr3_vid_pkg;
    localparam int BURST_BEATS = 16;
    localparam int BURST_WORDS = 128;
    localparam int NUM_FRAMES  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } wr_state_t;

    typedef logic [1:0] frame_idx_t;

    function automatic frame_idx_t frame_idx_inc(input frame_idx_t idx);
        return (idx >= frame_idx_t'(NUM_FRAMES - 1)) ? 2'd0 : idx + 2'd1;
    endfunction
endpackage

// File: rtl/ddr3_wr_addr_gen_if.sv
// Bus between the video packer / DDR3 arbiter side and ddr3_wr_addr_gen.
// Handshake: awaddr is valid while awaddr_empty=0; an awaddr_ref high at a clk edge pops that entry.
interface ddr3_wr_addr_gen_if #(parameter int ADDR_W = 28);
    import ddr3_vid_pkg::*;

    logic              frame_start;
    logic              beat_in;
    frame_idx_t        rd_frame_idx;
    logic              awaddr_ref;
    logic [ADDR_W-1:0] awaddr;
    logic              awaddr_empty;
    logic              frame_done;
    frame_idx_t        done_frame_idx;
    logic              err_ovf;
    logic              err_short;
    wr_state_t         dbg_state;
    logic [9:0]        dbg_beat_cnt;

    modport master (
        output frame_start, beat_in, rd_frame_idx, awaddr_ref,
        input  awaddr, awaddr_empty, frame_done, done_frame_idx,
        input  err_ovf, err_short, dbg_state, dbg_beat_cnt
    );

    modport slave (
        input  frame_start, beat_in, rd_frame_idx, awaddr_ref,
        output awaddr, awaddr_empty, frame_done, done_frame_idx,
        output err_ovf, err_short, dbg_state, dbg_beat_cnt
    );
endinterface

// File: rtl/ddr3_addr_fifo.sv
// Synchronous show-ahead FIFO: o_rd_data is the head entry while o_empty=0.
module ddr3_addr_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_wr;
    logic             w_rd;

    // A write into a full FIFO is accepted only when the head leaves in the same cycle.
    assign w_wr = i_wr_en && (!o_full || i_rd_en);
    assign w_rd = i_rd_en && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
endmodule

// File: rtl/ddr3_wr_addr_gen.sv
// DDR3 write-burst address generator over a triple-buffered frame set.
// Optional WR_SKIP_RD_FRAME_EN: frame rotation skips the frame being displayed.
module ddr3_wr_addr_gen
    import ddr3_vid_pkg::*;
#(
    parameter int              ADDR_W       = 28,
    parameter int              FRAME_WORDS  = 921600,
    parameter logic [ADDR_W-1:0] FRAME_BASE0  = 28'h0000000,
    parameter logic [ADDR_W-1:0] FRAME_STRIDE = 28'h0100000,
    parameter int              AFIFO_DEPTH  = 4
) (
    input  logic clk_100M,
    input  logic rst,
    ddr3_wr_addr_gen_if.slave bus
);
    localparam int FRAME_BURSTS = FRAME_WORDS / BURST_WORDS;
    localparam int BI_W         = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
    localparam logic [BI_W-1:0] LAST_BURST = BI_W'(FRAME_BURSTS - 1);

    wr_state_t         r_state;
    frame_idx_t        r_idx;
    logic [9:0]        r_beat_cnt;
    logic [BI_W-1:0]   r_burst_idx;
    logic [ADDR_W-1:0] r_cur_addr;
    logic              r_fs_pend;
    logic              r_frame_done;
    frame_idx_t        r_done_idx;
    logic              r_err_ovf;
    logic              r_err_short;

    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic [10:0]       w_beat_sum;
    frame_idx_t        w_rot1;
    frame_idx_t        w_next_idx;
    logic [ADDR_W-1:0] w_rd_data;

    function automatic logic [ADDR_W-1:0] frame_base(input frame_idx_t idx);
        case (idx)
            2'd0:    return FRAME_BASE0;
            2'd1:    return FRAME_BASE0 + FRAME_STRIDE;
            default: return FRAME_BASE0 + FRAME_STRIDE + FRAME_STRIDE;
        endcase
    endfunction

    assign w_rot1 = frame_idx_inc(r_idx);
`ifdef WR_SKIP_RD_FRAME_EN
    assign w_next_idx = (w_rot1 == bus.rd_frame_idx) ? frame_idx_inc(w_rot1) : w_rot1;
`else
    logic w_unused_rd;
    assign w_unused_rd = ^bus.rd_frame_idx;
    assign w_next_idx  = w_rot1;
`endif

    assign w_pop  = bus.awaddr_ref && !w_empty;
    assign w_push = (r_state == ST_RUN) && !bus.frame_start &&
                    (r_beat_cnt >= 10'(BURST_BEATS)) && (!w_full || w_pop);
    // Bit 10 set means an increment past 1023 with no push to offset it.
    assign w_beat_sum = {1'b0, r_beat_cnt} + 11'(bus.beat_in) -
                        (w_push ? 11'(BURST_BEATS) : 11'd0);

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_beat_cnt   <= '0;
            r_burst_idx  <= '0;
            r_cur_addr   <= FRAME_BASE0;
            r_fs_pend    <= 1'b0;
            r_frame_done <= 1'b0;
            r_done_idx   <= '0;
            r_err_ovf    <= 1'b0;
            r_err_short  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (bus.awaddr_ref && w_empty) r_err_ovf <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (bus.frame_start || r_fs_pend) begin
                        r_state     <= ST_RUN;
                        r_fs_pend   <= 1'b0;
                        r_cur_addr  <= frame_base(r_idx);
                        r_burst_idx <= '0;
                    end
                end
                ST_RUN: begin
                    if (bus.frame_start) begin
                        // Truncated frame: abandon it and restart on the next buffer.
                        r_err_short <= 1'b1;
                        r_idx       <= w_next_idx;
                        r_burst_idx <= '0;
                        r_beat_cnt  <= '0;
                        r_cur_addr  <= frame_base(w_next_idx);
                    end else begin
                        if (w_beat_sum[10]) begin
                            r_beat_cnt <= 10'h3FF;
                            r_err_ovf  <= 1'b1;
                        end else begin
                            r_beat_cnt <= w_beat_sum[9:0];
                        end
                        if (w_push) begin
                            r_cur_addr  <= r_cur_addr + ADDR_W'(BURST_WORDS);
                            r_burst_idx <= r_burst_idx + BI_W'(1);
                            if (r_burst_idx == LAST_BURST) begin
                                r_state      <= ST_DONE;
                                r_frame_done <= 1'b1;
                                r_done_idx   <= r_idx;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    r_idx   <= w_next_idx;
                    r_state <= ST_IDLE;
                    if (bus.frame_start) r_fs_pend <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    ddr3_addr_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (AFIFO_DEPTH)
    ) u_fifo (
        .i_clk     (clk_100M),
        .i_rst     (rst),
        .i_wr_en   (w_push),
        .i_wr_data (r_cur_addr),
        .i_rd_en   (bus.awaddr_ref),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign bus.awaddr         = w_rd_data;
    assign bus.awaddr_empty   = w_empty;
    assign bus.frame_done     = r_frame_done;
    assign bus.done_frame_idx = r_done_idx;
    assign bus.err_ovf        = r_err_ovf;
    assign bus.err_short      = r_err_short;
    assign bus.dbg_state      = r_state;
    assign bus.dbg_beat_cnt   = r_beat_cnt;
endmodule

// File: tb/tb_ddr3_wr_addr_gen.sv
// Directed scoreboard bench for ddr3_wr_addr_gen (8-burst frames, 4-deep address FIFO).
module tb_ddr3_wr_addr_gen;
    import ddr3_vid_pkg::*;

    localparam int          ADDR_W = 28;
    localparam logic [27:0] BASE0  = 28'h0000000;
    localparam logic [27:0] STRIDE = 28'h0100000;

    logic clk_100M = 1'b0;
    logic rst      = 1'b1;
    logic pop_auto = 1'b0;
    logic pop_man  = 1'b0;
    logic drain_en = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [ADDR_W-1:0] exp_q[$];
    logic [1:0]        done_q[$];

    ddr3_wr_addr_gen_if #(.ADDR_W(ADDR_W)) bus ();

    ddr3_wr_addr_gen #(
        .ADDR_W       (ADDR_W),
        .FRAME_WORDS  (1024),
        .FRAME_BASE0  (BASE0),
        .FRAME_STRIDE (STRIDE),
        .AFIFO_DEPTH  (4)
    ) dut (
        .clk_100M (clk_100M),
        .rst      (rst),
        .bus      (bus)
    );

    assign bus.awaddr_ref = pop_auto | pop_man;

    always #5 clk_100M = ~clk_100M;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    // Arbiter model: pops whenever enabled and an entry is present.
    initial begin
        forever begin
            @(posedge clk_100M); #1;
            pop_auto = drain_en && !bus.awaddr_empty;
        end
    end

    // Monitor: every real pop and every frame_done is checked against the queues.
    always @(negedge clk_100M) begin
        if (!rst && bus.awaddr_ref && !bus.awaddr_empty) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_awaddr: got 0x%0h, expected no entry", bus.awaddr);
            end else begin
                check("awaddr", 32'(bus.awaddr), 32'(exp_q.pop_front()));
            end
        end
        if (!rst && bus.frame_done) begin
            if (done_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_frame_done: got idx %0d, expected no pulse", bus.done_frame_idx);
            end else begin
                check("done_frame_idx", 32'(bus.done_frame_idx), 32'(done_q.pop_front()));
            end
        end
    end

    task automatic do_reset();
        drain_en = 1'b0;
        pop_man  = 1'b0;
        bus.frame_start  = 1'b0;
        bus.beat_in      = 1'b0;
        bus.rd_frame_idx = 2'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk_100M);
        #1;
        rst = 1'b0;
        exp_q.delete();
        done_q.delete();
    endtask

    task automatic pulse_frame_start();
        bus.frame_start = 1'b1;
        @(posedge clk_100M); #1;
        bus.frame_start = 1'b0;
    endtask

    task automatic send_beats(input int n);
        for (int i = 0; i < n; i++) begin
            bus.beat_in = 1'b1;
            @(posedge clk_100M); #1;
        end
        bus.beat_in = 1'b0;
    endtask

    task automatic pop_once();
        pop_man = 1'b1;
        @(posedge clk_100M); #1;
        pop_man = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || !bus.awaddr_empty) && k < 100) begin
            @(posedge clk_100M); #1;
            k++;
        end
        repeat (4) @(posedge clk_100M);
        #1;
        check({name, "_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic push_frame_addrs(input logic [27:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 28'(i * 128));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state and first-burst latency.
        do_reset();
        check("rst_awaddr",       32'(bus.awaddr), 32'd0);
        check("rst_empty",        32'(bus.awaddr_empty), 32'd1);
        check("rst_frame_done",   32'(bus.frame_done), 32'd0);
        check("rst_done_idx",     32'(bus.done_frame_idx), 32'd0);
        check("rst_err_ovf",      32'(bus.err_ovf), 32'd0);
        check("rst_err_short",    32'(bus.err_short), 32'd0);
        check("rst_state",        32'(bus.dbg_state), 32'(ST_IDLE));
        check("rst_beat_cnt",     32'(bus.dbg_beat_cnt), 32'd0);
        pulse_frame_start();
        check("fs_to_run",        32'(bus.dbg_state), 32'(ST_RUN));
        exp_q.push_back(28'h0000000);
        send_beats(16);
        check("beat16_cnt",       32'(bus.dbg_beat_cnt), 32'd16);
        check("beat16_empty",     32'(bus.awaddr_empty), 32'd1);
        @(posedge clk_100M); #1;
        check("push_empty",       32'(bus.awaddr_empty), 32'd0);
        check("push_awaddr",      32'(bus.awaddr), 32'd0);
        pop_once();
        check("pop_empty",        32'(bus.awaddr_empty), 32'd1);

        // Full frame with an arbiter draining, then the next buffer.
        do_reset();
        drain_en = 1'b1;
        push_frame_addrs(BASE0, 8);
        done_q.push_back(2'd0);
        pulse_frame_start();
        send_beats(128);
        wait_drain("frame0");
        check("frame0_done_cnt",  32'(done_q.size()), 32'd0);
        check("frame0_idle",      32'(bus.dbg_state), 32'(ST_IDLE));
        check("frame0_done_hold", 32'(bus.done_frame_idx), 32'd0);
`ifdef WR_SKIP_RD_FRAME_EN
        push_frame_addrs(BASE0 + STRIDE, 2);
`else
        push_frame_addrs(BASE0 + STRIDE, 2);
`endif
        pulse_frame_start();
        send_beats(32);
        wait_drain("frame1");

        // Backpressure: FIFO fills at 4, counter holds, a pop releases the 5th push.
        do_reset();
        push_frame_addrs(BASE0, 6);
        pulse_frame_start();
        send_beats(96);
        repeat (3) @(posedge clk_100M);
        #1;
        check("bp_cnt_held",      32'(bus.dbg_beat_cnt), 32'd32);
        check("bp_not_empty",     32'(bus.awaddr_empty), 32'd0);
        pop_once();
        check("bp_5th_push_cnt",  32'(bus.dbg_beat_cnt), 32'd16);
        drain_en = 1'b1;
        wait_drain("bp");
        check("bp_cnt_final",     32'(bus.dbg_beat_cnt), 32'd0);

        // Short frame: restart on the next buffer, no frame_done.
        do_reset();
        drain_en = 1'b1;
        push_frame_addrs(BASE0, 2);
        pulse_frame_start();
        send_beats(32);
        wait_drain("short_a");
        pulse_frame_start();
        check("short_err",        32'(bus.err_short), 32'd1);
        check("short_cnt_clr",    32'(bus.dbg_beat_cnt), 32'd0);
        check("short_state",      32'(bus.dbg_state), 32'(ST_RUN));
        push_frame_addrs(BASE0 + STRIDE, 2);
        send_beats(32);
        wait_drain("short_b");
        check("short_no_done",    32'(bus.done_frame_idx), 32'd0);

        // Rotation with the display reading frame 1.
        do_reset();
        drain_en = 1'b1;
        bus.rd_frame_idx = 2'd1;
        push_frame_addrs(BASE0, 8);
        done_q.push_back(2'd0);
        pulse_frame_start();
        send_beats(128);
        wait_drain("skip_f0");
`ifdef WR_SKIP_RD_FRAME_EN
        exp_q.push_back(BASE0 + STRIDE + STRIDE);
`else
        exp_q.push_back(BASE0 + STRIDE);
`endif
        pulse_frame_start();
        send_beats(16);
        wait_drain("skip_next");
        check("skip_err_short",   32'(bus.err_short), 32'd0);

        // Pop while empty is ignored but flagged.
        do_reset();
        pop_once();
        check("empty_pop_ovf",    32'(bus.err_ovf), 32'd1);
        check("empty_pop_empty",  32'(bus.awaddr_empty), 32'd1);
        check("empty_pop_addr",   32'(bus.awaddr), 32'd0);
        drain_en = 1'b1;
        exp_q.push_back(BASE0);
        pulse_frame_start();
        send_beats(16);
        wait_drain("after_empty_pop");

        // Beat counter saturation with the FIFO stuck full.
        do_reset();
        pulse_frame_start();
        send_beats(1087);
        check("sat_cnt_1023",     32'(bus.dbg_beat_cnt), 32'd1023);
        check("sat_no_ovf_yet",   32'(bus.err_ovf), 32'd0);
        send_beats(1);
        check("sat_cnt_held",     32'(bus.dbg_beat_cnt), 32'd1023);
        check("sat_ovf",          32'(bus.err_ovf), 32'd1);
        check("sat_fifo_kept",    32'(bus.awaddr), 32'd0);
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
